// File: rtl/tt_adder_pkg.sv
// Shared types and constants for the multi-byte adder tile.
// Holds the FSM state enum, uio bit positions, op encoding and the uio_oe value.
package tt_adder_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        ADD    = 3'd3,
        DONE   = 3'd4
    } state_e;

    // uio_in bit positions
    localparam int unsigned VALID  = 0;
    localparam int unsigned OP     = 1;
    localparam int unsigned ACC    = 2;
    localparam int unsigned RD     = 3;
    // uio_out bit positions
    localparam int unsigned BUSY   = 4;
    localparam int unsigned OVALID = 5;
    localparam int unsigned COUT   = 6;
    localparam int unsigned OVF    = 7;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic [7:0] UIO_OE_VAL = 8'hF0;

endpackage

// File: rtl/adder_byte_slice.sv
// Combinational 8-bit slice: sum_o = a_i + b_i + cin_i.
// Ports: a_i, b_i operand bytes (b_i already inverted for subtraction),
//        cin_i carry in; sum_o result byte, cout_o carry out,
//        ovf_o signed-overflow term (meaningful for the MSB slice only).
module adder_byte_slice (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] sum_o,
    output logic       cout_o,
    output logic       ovf_o
);

    logic [8:0] full_c;

    assign full_c = 9'(a_i) + 9'(b_i) + 9'(cin_i);
    assign sum_o  = full_c[7:0];
    assign cout_o = full_c[8];
    // Overflow when both operands share a sign that the sum does not.
    assign ovf_o  = (a_i[7] == b_i[7]) && (sum_o[7] != a_i[7]);

endmodule

// File: rtl/tt_um_multibyte_adder.sv
// Byte-serial WIDTH-bit add/sub tile with accumulator and idle timeout.
// Ports: clk, rst_n (async active-low), ena (freezes all state when low),
//        ui_in operand byte, uio_in {rd_next, acc, op, valid} in [3:0],
//        uo_out result byte, uio_out {ovf, cout, out_valid, busy, 4'b0},
//        uio_oe constant 8'hF0.
// Build option: define SATURATE_EN to clamp results on unsigned carry/borrow.
module tt_um_multibyte_adder
    import tt_adder_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned MAX_COUNT = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned NB = WIDTH / 8;
    localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned TW = $clog2(MAX_COUNT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(MAX_COUNT - 1);

    state_e               state_q, state_d;
    logic [NB-1:0][7:0]   a_q, a_d;
    logic [NB-1:0][7:0]   b_q, b_d;
    logic [NB-1:0][7:0]   r_q, r_d;
    logic [NB-1:0][7:0]   acc_q, acc_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic                 op_q, op_d;
    logic                 carry_q, carry_d;
    logic                 cout_q, cout_d;
    logic                 ovf_q, ovf_d;
    logic [7:0]           uo_out_q, uo_out_d;
    logic [7:0]           uio_out_q, uio_out_d;

    logic                 valid_c, rd_c, op_in_c, acc_in_c;
    logic [3:0]           unused_uio_c;
    logic [7:0]           sl_a_c, sl_b_c, sl_sum_c;
    logic                 sl_cout_c, sl_ovf_c;
    logic [NB-1:0][7:0]   r_out_c;

    assign valid_c      = uio_in[VALID];
    assign op_in_c      = uio_in[OP];
    assign acc_in_c     = uio_in[ACC];
    assign rd_c         = uio_in[RD];
    assign unused_uio_c = uio_in[7:4];

    // Single slice shared across all ADD cycles, indexed by the byte counter.
    assign sl_a_c = a_q[idx_q];
    assign sl_b_c = (op_q == OP_SUB) ? ~b_q[idx_q] : b_q[idx_q];

    adder_byte_slice u_slice (
        .a_i    (sl_a_c),
        .b_i    (sl_b_c),
        .cin_i  (carry_q),
        .sum_o  (sl_sum_c),
        .cout_o (sl_cout_c),
        .ovf_o  (sl_ovf_c)
    );

    // Result as presented and committed to the accumulator.
`ifdef SATURATE_EN
    always_comb begin
        r_out_c = r_q;
        if ((op_q == OP_ADD) && cout_q) begin
            r_out_c = '1;
        end else if ((op_q == OP_SUB) && !cout_q) begin
            r_out_c = '0;
        end
    end
`else
    assign r_out_c = r_q;
`endif

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        r_d       = r_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        op_d      = op_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        uo_out_d  = 8'h00;
        uio_out_d = 8'h00;

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (valid_c) begin
                    op_d = op_in_c;
                    if (!acc_in_c) begin
                        a_d[0] = ui_in;
                        if (NB == 1) begin
                            state_d = LOAD_B;
                            idx_d   = '0;
                        end else begin
                            state_d = LOAD_A;
                            idx_d   = IW'(1);
                        end
                    end else begin
                        a_d    = acc_q;
                        b_d[0] = ui_in;
                        if (NB == 1) begin
                            state_d = ADD;
                            idx_d   = '0;
                            carry_d = (op_in_c == OP_SUB);
                        end else begin
                            state_d = LOAD_B;
                            idx_d   = IW'(1);
                        end
                    end
                end
            end

            LOAD_A, LOAD_B: begin
                if (valid_c) begin
                    tmo_d = '0;
                    if (state_q == LOAD_A) begin
                        a_d[idx_q] = ui_in;
                    end else begin
                        b_d[idx_q] = ui_in;
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (state_q == LOAD_A) begin
                            state_d = LOAD_B;
                        end else begin
                            state_d = ADD;
                            // Subtraction is A + ~B + 1
                            carry_d = (op_q == OP_SUB);
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            ADD: begin
                tmo_d        = '0;
                r_d[idx_q]   = sl_sum_c;
                carry_d      = sl_cout_c;
                if (idx_q == LAST_IDX) begin
                    cout_d  = sl_cout_c;
                    ovf_d   = sl_ovf_c;
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end

            DONE: begin
                if (rd_c) begin
                    tmo_d = '0;
                    if (idx_q == LAST_IDX) begin
                        acc_d   = r_out_c;
                        cout_d  = 1'b0;
                        ovf_d   = 1'b0;
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else if (tmo_q == TMO_LAST) begin
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                    idx_d   = '0;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                idx_d   = '0;
                tmo_d   = '0;
            end
        endcase

        // Outputs reflect the current state, registered one cycle later.
        if (state_q == DONE) begin
            uo_out_d = r_out_c[idx_q];
        end
        uio_out_d[BUSY]   = (state_q != IDLE);
        uio_out_d[OVALID] = (state_q == DONE);
        uio_out_d[COUT]   = cout_q;
        uio_out_d[OVF]    = ovf_q;
    end

    // State register; everything holds while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            tmo_q     <= '0;
            op_q      <= 1'b0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            uo_out_q  <= 8'h00;
            uio_out_q <= 8'h00;
        end else if (ena) begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            r_q       <= r_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            op_q      <= op_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
            uo_out_q  <= uo_out_d;
            uio_out_q <= uio_out_d;
        end
    end

    assign uo_out  = uo_out_q;
    assign uio_out = uio_out_q;
    assign uio_oe  = UIO_OE_VAL;

endmodule

// File: doc/tt_um_multibyte_adder.md
Name: tt_um_multibyte_adder

Overview:
Parametrised successor of the single-byte parallel adder tile. It takes two WIDTH-bit operands over the 8-bit dedicated inputs, one byte per strobe, LSB first. It adds or subtracts them byte-serially with a registered carry, then returns the result one byte per read strobe. It keeps an accumulator for chained operations and aborts stalled transactions with an idle timeout. It sits as a standalone Tiny Tapeout user tile.

Parameters:
WIDTH, 16, operand/result width in bits; multiple of 8, range 8..64; NB = WIDTH/8 bytes
MAX_COUNT, 10_000_000, idle-timeout length in cycles; the bench overrides it to 1000

Ports:
clk  in  1  tile clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  design-selected; when low, all state freezes
ui_in  in  8  operand data byte
uio_in  in  8  [0] valid strobe, [1] op (0 add, 1 sub), [2] acc mode, [3] rd_next; [7:4] ignored
uo_out  out  8  current result byte
uio_out  out  8  [4] busy, [5] out_valid, [6] cout, [7] ovf; [3:0] = 0
uio_oe  out  8  constant 8'hF0

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, accumulator 0, byte index 0, carry 0, timeout counter 0, uo_out 0, uio_out 0. uio_oe is always 8'hF0.
- Sampling: all inputs are sampled on the rising clk edge, and only when ena=1. When ena=0, no register changes.
- States: IDLE, LOAD_A, LOAD_B, ADD, DONE. busy = (state != IDLE).
- IDLE: a valid byte latches op and acc from that same cycle; both hold for the whole transaction.
  - acc=0: the byte goes to A[7:0]; go to LOAD_A, or straight to LOAD_B if NB=1.
  - acc=1: A = accumulator, the byte goes to B[7:0]; go to LOAD_B, or straight to ADD if NB=1.
- LOAD_A / LOAD_B: each valid byte fills the next byte LSB-first. After byte NB-1: LOAD_A goes to LOAD_B, and LOAD_B goes to ADD. Cycles without valid are allowed.
- ADD: NB cycles, one byte per cycle.
  - R[k] = A[k] + (op ? ~B[k] : B[k]) + c; the carry register c starts at op.
  - After the final slice: cout = carry out of the MSB; ovf = signed overflow of the MSB slice.
  - Latency: out_valid rises NB+1 cycles after the edge that accepts the last B byte.
- DONE:
  - out_valid=1; uo_out = R[rd_idx], with rd_idx starting at 0.
  - rd_next advances rd_idx. rd_next at rd_idx=NB-1 writes R to the accumulator, clears the flags and returns to IDLE.
  - cout/ovf are held for the whole of DONE. For subtraction, cout=1 means no borrow.
- Ignored events: valid in ADD or DONE, and rd_next outside DONE. If valid and rd_next arrive together in DONE, only rd_next acts.
- Timeout: in LOAD_A, LOAD_B and DONE the counter increments each enabled cycle and clears on any accepted valid or rd_next. When it reaches MAX_COUNT-1, the FSM returns to IDLE, the partial data is discarded and the accumulator is unchanged. The counter is cleared in IDLE and ADD.
- Wrap: results wrap modulo 2^WIDTH.
- Reset mid-operation: immediately returns everything to the reset values, including the accumulator.

Optional Feature:
SATURATE_EN
- Defined: in DONE, if an add has cout=1, every byte of uo_out reads 8'hFF; if a sub has cout=0, every byte reads 8'h00. The accumulator receives the saturated value. Flags are unchanged.
- Undefined: wrapping arithmetic only; no saturation logic is built.

Decomposition:
- Package tt_adder_pkg holds:
  - the state enum
  - uio bit-index localparams: VALID=0, OP=1, ACC=2, RD=3, BUSY=4, OVALID=5, COUT=6, OVF=7
  - op encoding OP_ADD=0, OP_SUB=1
  - UIO_OE_VAL = 8'hF0
- Sub-module adder_byte_slice: combinational 8-bit a+b+cin producing sum, cout and the MSB-slice signed-overflow term. It is instantiated once and reused each ADD cycle.

Test Plan:
All cases use WIDTH=16, MAX_COUNT=1000.
1. Add A=0x1234, B=0x0FCD -> out_valid 3 cycles after the last B byte; reads 0x01 then 0x22; cout=0, ovf=0.
2. Carry and overflow:
   - 0xFFFF+0x0001 -> 0x0000, cout=1, ovf=0.
   - 0x7FFF+0x0001 -> 0x8000, ovf=1.
3. Subtract:
   - 0x0005-0x0007 -> 0xFFFE, cout=0.
   - 0x8000-0x0001 -> 0x7FFF, ovf=1.
   - With SATURATE_EN, the first case reads 0x00, 0x00.
4. Accumulate: after case 1 is fully read out, acc=1 with B=0x0100 -> 0x2301. A second read-out leaves 0x2301 in the accumulator.
5. Timeout: send a single A byte, then hold idle 1000 cycles -> busy=0. A following normal transaction is correct, and the accumulator is unchanged. The same check runs for a stall in DONE.
6. Freeze and reset:
   - ena=0 for 20 cycles mid-LOAD_B -> state and outputs hold.
   - rst_n low during ADD -> uo_out=0, uio_out=0, accumulator 0 asynchronously.
